block_pipeline_scheduler: RTL and testbench
===========================================

# block_pipeline_scheduler

Sequences the per-block decode pipeline for one frame. The lossless decode/dequantization engine (M3) fills one half of a ping-pong S-buffer while the IDCT engine (M2) consumes the other half. The block walks every 8x8 block of the Y, U and V planes in order, issues start pulses and buffer selects, and arbitrates the single SRAM port between the two engines. It sits in the top level between the frame-level controller and the M2/M3 engines.

## Interface
Parameters:
- Y_COLS, 40, Y blocks per row
- Y_ROWS, 30, Y block rows
- UV_COLS, 20, U/V blocks per row
- UV_ROWS, 30, U/V block rows

Ports:
- CLOCK_50_I  in  1  clock (50 MHz)
- Resetn  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse; honoured only in IDLE
- done  out  1  one-cycle pulse when the last block's IDCT completes
- m3_start  out  1  one-cycle pulse: decode the next block into buffer buf_sel
- m3_done  in  1  one-cycle pulse from M3
- m2_start  out  1  one-cycle pulse: IDCT the block in buffer ~buf_sel
- m2_done  in  1  one-cycle pulse from M2
- buf_sel  out  1  S-buffer half owned by M3
- m2_plane  out  2  plane of the block M2 processes (0=Y, 1=U, 2=V)
- m2_row  out  5  block row for M2
- m2_col  out  6  block column for M2
- m3_req, m2_req  in  1 each  SRAM requests, held high while access is needed
- m3_grant, m2_grant  out  1 each  registered grants, mutually exclusive
- m3_sram_address  in  18  M3 read address
- m2_sram_address  in  18  M2 address
- m2_sram_write_data  in  16  M2 write data
- m2_sram_we_n  in  1  M2 write enable, active-low
- SRAM_address  out  18  muxed SRAM address
- SRAM_write_data  out  16  muxed write data
- SRAM_we_n  out  1  muxed write enable

## Operation
- FSM states: IDLE, FILL, RUN, DRAIN, FIN.
- IDLE
  - On start: clear counters, buf_sel=0, pulse m3_start, go to FILL.
- FILL
  - Wait for m3_done.
  - Then toggle buf_sel, pulse m2_start with coordinates of block 0.
  - If more than one block remains, also pulse m3_start (same cycle) and go to RUN. Otherwise go to DRAIN.
- RUN
  - Sticky flags d3/d2 latch m3_done/m2_done. Same-cycle or either-order arrival is legal.
  - When d3&d2: clear flags, toggle buf_sel, advance M2 coordinates, pulse m2_start.
  - If the decode counter has not reached the last block, pulse m3_start and stay in RUN. Otherwise go to DRAIN.
- DRAIN
  - On m2_done: pulse done, go to FIN.
- FIN
  - Return to IDLE next cycle.
- Block order: plane Y, then U, then V. Within a plane, raster order (col fastest).
  - Y uses Y_COLS x Y_ROWS; U/V use UV_COLS x UV_ROWS.
  - Wrap: col reaches limit-1 -> col=0, row+1. Row reaches limit-1 at col limit-1 -> row=0, plane+1.
  - Default total: 1200+600+600 = 2400 blocks.
- Separate decode counter (12-bit block index) tracks M3 progress. Exactly total m3_start and total m2_start pulses per frame.
- Done pulses in states that are not waiting for them are ignored.
- start outside IDLE is ignored.
- Arbiter
  - With no grant held, next-cycle grant goes to m2 if m2_req, else m3 if m3_req.
  - A grant is held while its req stays high.
  - On release the grant drops for at least one cycle. The other requester is granted in the following cycle.
- Mux (combinational on registered grants)
  - m2_grant: M2 signals.
  - m3_grant: m3_sram_address, SRAM_write_data=0, SRAM_we_n=1.
  - No grant: address 0, write data 0, SRAM_we_n=1.

## Timing
- Reset values:
  - state IDLE
  - done, m3_start, m2_start, buf_sel, grants = 0
  - m2_plane/row/col = 0
  - SRAM_address, SRAM_write_data = 0; SRAM_we_n = 1
- Latencies:
  - start to m3_start: 1 cycle (registered).
  - Last of m3_done/m2_done to m2_start/m3_start: 1 cycle.
  - buf_sel and m2 coordinates change in the same cycle as the m2_start pulse.
- Grant latency: 1 cycle after req rise (if free); 0 cycles added after release beyond the 1 idle cycle.
- Reset mid-frame aborts immediately and returns all outputs to reset values. No done pulse is issued.

## Test plan
- Y_COLS=2,Y_ROWS=1,UV_COLS=1,UV_ROWS=1; start; M2/M3 model done after 10 cycles -> 4 m3_start, 4 m2_start, m2 (plane,row,col) sequence (0,0,0),(0,0,1),(1,0,0),(2,0,0), buf_sel alternates 1,0,1,0, one done pulse.
- Default parameters, fast models -> exactly 2400 m2_start; last coordinates (2,29,19); done once.
- m2_done and m3_done in the same cycle, and m2_done 5 cycles before m3_done -> next starts exactly 1 cycle after the later done.
- Both reqs rise together -> m2_grant next cycle. m2_req drops -> one idle cycle, then m3_grant. SRAM_we_n=1 throughout M3 grant.
- Reset asserted in RUN -> all outputs at reset values; start afterwards runs a full frame correctly.
- start pulsed during RUN and spurious m3_done in DRAIN -> no effect on counts or ordering.

Source files
------------

// File: rtl/block_pipeline_scheduler.sv
// Per-frame block sequencer for the M3 (decode) / M2 (IDCT) ping-pong pipeline.
// Walks Y, U, V blocks in raster order and arbitrates the shared SRAM port.
module block_pipeline_scheduler #(
    parameter int Y_COLS  = 40,
    parameter int Y_ROWS  = 30,
    parameter int UV_COLS = 20,
    parameter int UV_ROWS = 30
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    output logic        done,
    output logic        m3_start,
    input  logic        m3_done,
    output logic        m2_start,
    input  logic        m2_done,
    output logic        buf_sel,
    output logic [1:0]  m2_plane,
    output logic [4:0]  m2_row,
    output logic [5:0]  m2_col,
    input  logic        m3_req,
    input  logic        m2_req,
    output logic        m3_grant,
    output logic        m2_grant,
    input  logic [17:0] m3_sram_address,
    input  logic [17:0] m2_sram_address,
    input  logic [15:0] m2_sram_write_data,
    input  logic        m2_sram_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    localparam int          TOTAL       = Y_COLS * Y_ROWS + 2 * UV_COLS * UV_ROWS;
    localparam logic [11:0] TOTAL_C     = 12'(TOTAL);
    localparam logic [5:0]  Y_COL_LAST  = 6'(Y_COLS - 1);
    localparam logic [5:0]  UV_COL_LAST = 6'(UV_COLS - 1);
    localparam logic [4:0]  Y_ROW_LAST  = 5'(Y_ROWS - 1);
    localparam logic [4:0]  UV_ROW_LAST = 5'(UV_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        m3_start_q, m3_start_d;
    logic        m2_start_q, m2_start_d;
    logic        buf_sel_q, buf_sel_d;
    logic [1:0]  plane_q, plane_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [11:0] dec_cnt_q, dec_cnt_d;
    logic        d3_q, d3_d;
    logic        d2_q, d2_d;
    logic        m3_grant_q, m3_grant_d;
    logic        m2_grant_q, m2_grant_d;

    logic        d3_now, d2_now;
    logic [5:0]  col_last;
    logic [4:0]  row_last;

    assign d3_now   = d3_q | m3_done;
    assign d2_now   = d2_q | m2_done;
    assign col_last = (plane_q == 2'd0) ? Y_COL_LAST : UV_COL_LAST;
    assign row_last = (plane_q == 2'd0) ? Y_ROW_LAST : UV_ROW_LAST;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            m3_start_q <= 1'b0;
            m2_start_q <= 1'b0;
            buf_sel_q  <= 1'b0;
            plane_q    <= 2'd0;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            dec_cnt_q  <= 12'd0;
            d3_q       <= 1'b0;
            d2_q       <= 1'b0;
            m3_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            m3_start_q <= m3_start_d;
            m2_start_q <= m2_start_d;
            buf_sel_q  <= buf_sel_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dec_cnt_q  <= dec_cnt_d;
            d3_q       <= d3_d;
            d2_q       <= d2_d;
            m3_grant_q <= m3_grant_d;
            m2_grant_q <= m2_grant_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        m3_start_d = 1'b0;
        m2_start_d = 1'b0;
        buf_sel_d  = buf_sel_q;
        plane_d    = plane_q;
        row_d      = row_q;
        col_d      = col_q;
        dec_cnt_d  = dec_cnt_q;
        d3_d       = d3_q;
        d2_d       = d2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dec_cnt_d  = 12'd1;
                    buf_sel_d  = 1'b0;
                    plane_d    = 2'd0;
                    row_d      = 5'd0;
                    col_d      = 6'd0;
                    d3_d       = 1'b0;
                    d2_d       = 1'b0;
                    m3_start_d = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                // Block 0 is decoded; its coordinates are already zero.
                if (m3_done) begin
                    buf_sel_d  = ~buf_sel_q;
                    m2_start_d = 1'b1;
                    if (dec_cnt_q < TOTAL_C) begin
                        m3_start_d = 1'b1;
                        dec_cnt_d  = dec_cnt_q + 12'd1;
                        state_d    = S_RUN;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_RUN: begin
                d3_d = d3_now;
                d2_d = d2_now;
                if (d3_now && d2_now) begin
                    d3_d       = 1'b0;
                    d2_d       = 1'b0;
                    buf_sel_d  = ~buf_sel_q;
                    m2_start_d = 1'b1;
                    if (col_q == col_last) begin
                        col_d = 6'd0;
                        if (row_q == row_last) begin
                            row_d   = 5'd0;
                            plane_d = plane_q + 2'd1;
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                    if (dec_cnt_q < TOTAL_C) begin
                        m3_start_d = 1'b1;
                        dec_cnt_d  = dec_cnt_q + 12'd1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (m2_done) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A released grant always yields one idle cycle before anyone is re-granted.
    always_comb begin
        m2_grant_d = 1'b0;
        m3_grant_d = 1'b0;
        if (m2_grant_q) begin
            m2_grant_d = m2_req;
        end else if (m3_grant_q) begin
            m3_grant_d = m3_req;
        end else if (m2_req) begin
            m2_grant_d = 1'b1;
        end else if (m3_req) begin
            m3_grant_d = 1'b1;
        end
    end

    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        if (m2_grant_q) begin
            SRAM_address    = m2_sram_address;
            SRAM_write_data = m2_sram_write_data;
            SRAM_we_n       = m2_sram_we_n;
        end else if (m3_grant_q) begin
            SRAM_address = m3_sram_address;
        end
    end

    assign done     = done_q;
    assign m3_start = m3_start_q;
    assign m2_start = m2_start_q;
    assign buf_sel  = buf_sel_q;
    assign m2_plane = plane_q;
    assign m2_row   = row_q;
    assign m2_col   = col_q;
    assign m3_grant = m3_grant_q;
    assign m2_grant = m2_grant_q;

endmodule

// File: tb/tb_block_pipeline_scheduler.sv
// Scoreboard bench for block_pipeline_scheduler with randomized M2/M3 engine
// latencies, random SRAM requests, a mid-frame reset and a full default frame.
module tb_block_pipeline_scheduler;

    localparam int Y_COLS  = 40;
    localparam int Y_ROWS  = 30;
    localparam int UV_COLS = 20;
    localparam int UV_ROWS = 30;
    localparam int TOTAL   = Y_COLS * Y_ROWS + 2 * UV_COLS * UV_ROWS;

    logic        clk;
    logic        Resetn;
    logic        start;
    logic        done;
    logic        m3_start, m3_done;
    logic        m2_start, m2_done;
    logic        buf_sel;
    logic [1:0]  m2_plane;
    logic [4:0]  m2_row;
    logic [5:0]  m2_col;
    logic        m3_req, m2_req;
    logic        m3_grant, m2_grant;
    logic [17:0] m3_sram_address, m2_sram_address;
    logic [15:0] m2_sram_write_data;
    logic        m2_sram_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    block_pipeline_scheduler #(
        .Y_COLS(Y_COLS), .Y_ROWS(Y_ROWS), .UV_COLS(UV_COLS), .UV_ROWS(UV_ROWS)
    ) dut (
        .CLOCK_50_I(clk), .Resetn(Resetn), .start(start), .done(done),
        .m3_start(m3_start), .m3_done(m3_done), .m2_start(m2_start), .m2_done(m2_done),
        .buf_sel(buf_sel), .m2_plane(m2_plane), .m2_row(m2_row), .m2_col(m2_col),
        .m3_req(m3_req), .m2_req(m2_req), .m3_grant(m3_grant), .m2_grant(m2_grant),
        .m3_sram_address(m3_sram_address), .m2_sram_address(m2_sram_address),
        .m2_sram_write_data(m2_sram_write_data), .m2_sram_we_n(m2_sram_we_n),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard state, written only by the monitor (except exp_q pushes).
    logic [12:0] exp_q[$];
    int n3s, n2s, n3d, n2d;
    int t3d[TOTAL];
    int t2d[TOTAL];
    int cyc = 0;
    int tstart;
    bit active;
    int frames_done = 0;
    int exp_owner;

    // Stimulus controls.
    int lat_mode = 0;
    int inj3_req = 0;
    int inj3_ack = 0;
    bit req_mode = 1'b0;
    bit dir_m2 = 1'b0;
    bit dir_m3 = 1'b0;

    function automatic int pick_lat(input bit is_m3);
        case (lat_mode)
            1:       return 3;
            2:       return is_m3 ? 7 : 2;
            3:       return is_m3 ? 2 : 6;
            default: return int'($urandom_range(4, 1));
        endcase
    endfunction

    // M3 engine model
    initial begin : m3_engine
        int cnt;
        cnt = 0;
        m3_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m3_done = 1'b0;
            if (!Resetn) begin
                cnt = 0;
                continue;
            end
            if (inj3_req != inj3_ack) begin
                inj3_ack = inj3_req;
                m3_done  = 1'b1;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) m3_done = 1'b1;
            end
            if (m3_start) cnt = pick_lat(1'b1);
        end
    end

    // M2 engine model
    initial begin : m2_engine
        int cnt;
        cnt = 0;
        m2_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m2_done = 1'b0;
            if (!Resetn) begin
                cnt = 0;
                continue;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) m2_done = 1'b1;
            end
            if (m2_start) cnt = pick_lat(1'b0);
        end
    end

    // SRAM requesters: random traffic, or directed values from the main sequence
    initial begin : requesters
        m2_req = 1'b0;
        m3_req = 1'b0;
        m3_sram_address = '0;
        m2_sram_address = '0;
        m2_sram_write_data = '0;
        m2_sram_we_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m3_sram_address    = 18'($urandom);
            m2_sram_address    = 18'($urandom);
            m2_sram_write_data = 16'($urandom);
            if (req_mode) begin
                m2_req       = dir_m2;
                m3_req       = dir_m3;
                m2_sram_we_n = 1'b0;
            end else begin
                m2_sram_we_n = 1'($urandom);
                if (m2_req) m2_req = ($urandom_range(5, 0) != 0);
                else        m2_req = ($urandom_range(7, 0) == 0);
                if (m3_req) m3_req = ($urandom_range(5, 0) != 0);
                else        m3_req = ($urandom_range(7, 0) == 0);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse
    initial begin : monitor
        int k;
        int exp_t;
        bit ready;
        logic [12:0] got;
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!Resetn) begin
                n3s = 0; n2s = 0; n3d = 0; n2d = 0;
                active = 1'b0;
                exp_owner = 0;
                exp_q.delete();
                continue;
            end
            cyc++;

            // Arbiter: 0 none, 1 M2, 2 M3
            check("grant_m2", int'(m2_grant), int'(exp_owner == 1));
            check("grant_m3", int'(m3_grant), int'(exp_owner == 2));
            if (m2_grant) begin
                check("mux_addr_m2", int'(SRAM_address), int'(m2_sram_address));
                check("mux_wdata_m2", int'(SRAM_write_data), int'(m2_sram_write_data));
                check("mux_we_m2", int'(SRAM_we_n), int'(m2_sram_we_n));
            end else if (m3_grant) begin
                check("mux_addr_m3", int'(SRAM_address), int'(m3_sram_address));
                check("mux_wdata_m3", int'(SRAM_write_data), 0);
                check("mux_we_m3", int'(SRAM_we_n), 1);
            end else begin
                check("mux_addr_idle", int'(SRAM_address), 0);
                check("mux_we_idle", int'(SRAM_we_n), 1);
            end
            if (exp_owner == 1)      exp_owner = m2_req ? 1 : 0;
            else if (exp_owner == 2) exp_owner = m3_req ? 2 : 0;
            else                     exp_owner = m2_req ? 1 : (m3_req ? 2 : 0);

            if (m3_done && n3d < n3s) begin t3d[n3d] = cyc; n3d++; end
            if (m2_done && n2d < n2s) begin t2d[n2d] = cyc; n2d++; end

            if (start && !active) begin
                active = 1'b1;
                tstart = cyc;
            end

            if (m3_start) begin
                if (!active || n3s >= TOTAL) begin
                    check("m3_start_extra", 1, 0);
                end else begin
                    if (n3s == 0) begin
                        check("m3_start_lat", cyc, tstart + 1);
                    end else begin
                        check("m3_start_with_m2", int'(m2_start), 1);
                        check("m3_start_order", n2s, n3s - 1);
                    end
                    check("m3_buf_sel", int'(buf_sel), n3s % 2);
                    n3s++;
                end
            end

            if (m2_start) begin
                k = n2s;
                if (!active || k >= TOTAL || exp_q.size() == 0) begin
                    check("m2_start_extra", 1, 0);
                end else begin
                    if (k == 0) begin
                        ready = (n3d >= 1);
                        exp_t = ready ? t3d[0] + 1 : 0;
                    end else begin
                        ready = (n3d > k) && (n2d >= k);
                        exp_t = ready ? ((t3d[k] > t2d[k-1]) ? t3d[k] : t2d[k-1]) + 1 : 0;
                    end
                    if (!ready) check("m2_start_early", 1, 0);
                    else        check("m2_start_lat", cyc, exp_t);
                    e   = exp_q.pop_front();
                    got = {m2_plane, m2_row, m2_col};
                    check("m2_coord", int'(got), int'(e));
                    check("m2_buf_sel", int'(buf_sel), (k + 1) % 2);
                    n2s++;
                end
            end

            if (done) begin
                if (!active) begin
                    check("done_extra", 1, 0);
                end else begin
                    check("done_m2_count", n2s, TOTAL);
                    if (n2d == TOTAL) check("done_lat", cyc, t2d[TOTAL-1] + 1);
                    else              check("done_early", n2d, TOTAL);
                    active = 1'b0;
                    frames_done++;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_m3_start"}, int'(m3_start), 0);
        check({tag, "_m2_start"}, int'(m2_start), 0);
        check({tag, "_buf_sel"}, int'(buf_sel), 0);
        check({tag, "_grants"}, int'({m2_grant, m3_grant}), 0);
        check({tag, "_coord"}, int'({m2_plane, m2_row, m2_col}), 0);
        check({tag, "_addr"}, int'(SRAM_address), 0);
        check({tag, "_wdata"}, int'(SRAM_write_data), 0);
        check({tag, "_we_n"}, int'(SRAM_we_n), 1);
    endtask

    task automatic start_frame();
        int cols, rows;
        for (int p = 0; p < 3; p++) begin
            cols = (p == 0) ? Y_COLS : UV_COLS;
            rows = (p == 0) ? Y_ROWS : UV_ROWS;
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++)
                    exp_q.push_back({2'(p), 5'(r), 6'(c)});
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_n2(input int target, input int budget, input string nm);
        int i;
        i = 0;
        while (n2s < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (n2s < target) check(nm, n2s, target);
    endtask

    initial begin : main
        int i;
        Resetn = 1'b0;
        start  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset("por");
        @(posedge clk); #1 Resetn = 1'b1;
        repeat (3) @(posedge clk);

        // Frame aborted by reset part-way through RUN
        lat_mode = 0;
        start_frame();
        wait_n2(300, 8000, "timeout_abort_frame");
        @(posedge clk); #1 Resetn = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (3) @(posedge clk);
        #1 Resetn = 1'b1;
        repeat (3) @(posedge clk);
        check("no_done_after_abort", frames_done, 0);

        // Full frame: equal latencies, M2 finishing 5 cycles early, then random
        lat_mode = 1;
        start_frame();
        wait_n2(20, 2000, "timeout_same_cycle");
        lat_mode = 2;
        wait_n2(40, 2000, "timeout_m2_early");
        lat_mode = 0;
        wait_n2(200, 4000, "timeout_random");
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_n2(TOTAL - 5, 40000, "timeout_frame_body");
        lat_mode = 3;
        wait_n2(TOTAL, 1000, "timeout_frame_tail");
        @(posedge clk); #1 inj3_req++;
        i = 0;
        while (frames_done < 1 && i < 200) begin
            @(posedge clk);
            i++;
        end
        if (frames_done < 1) check("timeout_done", frames_done, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("frames_done_once", frames_done, 1);
        check("m3_start_total", n3s, TOTAL);
        check("m2_start_total", n2s, TOTAL);
        check("exp_q_empty", exp_q.size(), 0);
        check("last_plane", int'(m2_plane), 2);
        check("last_row", int'(m2_row), UV_ROWS - 1);
        check("last_col", int'(m2_col), UV_COLS - 1);

        // Directed arbitration sequence
        req_mode = 1'b1; dir_m2 = 1'b0; dir_m3 = 1'b0;
        repeat (4) @(negedge clk);
        check("arb_quiet", int'({m2_grant, m3_grant}), 0);
        dir_m2 = 1'b1; dir_m3 = 1'b1;
        @(negedge clk);
        check("arb_rise_no_grant_yet", int'({m2_grant, m3_grant}), 0);
        @(negedge clk);
        check("arb_both_m2_first", int'({m2_grant, m3_grant}), 2);
        check("arb_m2_addr", int'(SRAM_address), int'(m2_sram_address));
        check("arb_m2_we", int'(SRAM_we_n), 0);
        @(negedge clk);
        check("arb_m2_held", int'({m2_grant, m3_grant}), 2);
        dir_m2 = 1'b0;
        @(negedge clk);
        check("arb_m2_until_sampled", int'({m2_grant, m3_grant}), 2);
        @(negedge clk);
        check("arb_idle_gap", int'({m2_grant, m3_grant}), 0);
        @(negedge clk);
        check("arb_m3_after_gap", int'({m2_grant, m3_grant}), 1);
        check("arb_m3_wdata", int'(SRAM_write_data), 0);
        for (int j = 0; j < 3; j++) begin
            check("arb_m3_we_n", int'(SRAM_we_n), 1);
            check("arb_m3_addr", int'(SRAM_address), int'(m3_sram_address));
            @(negedge clk);
        end
        dir_m3 = 1'b0;
        repeat (3) @(negedge clk);
        check("arb_released", int'({m2_grant, m3_grant}), 0);
        req_mode = 1'b0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
